sysarr_load_sequencer: RTL and testbench
========================================

// Module: sysarr_load_sequencer
// PURPOSE
// Upstream feeder of the systolic array control unit. Accepts GEMM requests and two row streams from the
// memory subsystem: weight/input rows on one stream, partial-sum rows on the other. Drives the control
// unit's load strobes and row indices (input_en/weight_en/row_in_en, partial_en/row_ps_en) with
// registered row data. A new GEMM's input load is gated on the control unit's fifo_has_space.
// PARAMETERS
// N         4  systolic array dimension; rows per matrix
// DW       16  element width in bits; one row is N*DW bits
// MAX_PEND  2  max GEMMs whose inputs are loaded but whose partials are not yet fully loaded
// PORTS
// clk                   in   1                 clock
// RST                   in   1                 synchronous reset, active-high
// gemm_req_valid        in   1                 GEMM request valid
// gemm_req_new_weights  in   1                 1: N weight rows precede the N input rows
// gemm_req_ready        out  1                 GEMM request accepted when valid&ready
// row_valid             in   1                 weight/input row stream valid
// row_data              in   N*DW              weight/input row payload
// row_ready             out  1                 weight/input row accepted when valid&ready
// ps_valid              in   1                 partial-sum row stream valid
// ps_data               in   N*DW              partial-sum row payload
// ps_ready              out  1                 partial-sum row accepted when valid&ready
// fifo_has_space        in   1                 from control unit: array FIFOs can take a new GEMM
// input_en              out  1                 input row strobe
// weight_en             out  1                 weight row strobe
// row_in_en             out  $clog2(N)         row index for input_en/weight_en
// in_row_out            out  N*DW              row data for input_en/weight_en
// partial_en            out  1                 partial row strobe
// row_ps_en             out  $clog2(N)         row index for partial_en
// ps_row_out            out  N*DW              row data for partial_en
// busy                  out  1                 main state != IDLE or ps_pending != 0
// BEHAVIOUR
// - Reset (RST high at posedge): state=IDLE; row_cnt, ps_cnt, ps_pending=0; all strobes, indices and data
//   outputs =0. Applies mid-load too: partially loaded GEMMs are dropped and nothing is replayed.
// - Main FSM:
//   IDLE:       gemm_req_ready = (ps_pending < MAX_PEND). On accept, latch new_weights, go to WAIT_SPACE.
//   WAIT_SPACE: row_ready=0. When fifo_has_space=1, go to LOAD_W if new_weights, else LOAD_IN.
//   LOAD_W:     row_ready=1. Each accepted row produces a weight strobe; after row N-1, go to LOAD_IN.
//   LOAD_IN:    row_ready=1. Each accepted row produces an input strobe; after row N-1,
//               ps_pending++ and go to IDLE.
// - row_ready is 0 in IDLE and WAIT_SPACE; gemm_req_ready is 0 outside IDLE.
// - Strobe latency is 1 cycle. A handshake in cycle t gives, in cycle t+1:
//   input_en or weight_en = 1, row_in_en = row_cnt at t, in_row_out = row_data at t.
//   With no handshake, strobes are 0 next cycle; index and data hold their last values.
// - row_cnt increments per accepted row and wraps N-1 -> 0. input_en and weight_en are never both 1.
// - Partial stream: ps_ready = (ps_pending != 0). A handshake at t gives, at t+1:
//   partial_en=1, row_ps_en=ps_cnt, ps_row_out=ps_data.
//   ps_cnt wraps N-1 -> 0, and on that wrap ps_pending--.
// - ps_pending increment and decrement in the same cycle leave it unchanged. It never exceeds MAX_PEND
//   and never underflows.
// - The partial stream runs concurrently with LOAD_W/LOAD_IN; partial_en may coincide with input_en.
// - fifo_has_space is sampled only in WAIT_SPACE. Once loading starts it is ignored until the GEMM finishes.
// - A stalled stream (valid=0) holds the FSM and counters; there is no timeout.
// TESTING
// 1 Reset, then request new_weights=1 with fifo_has_space=1 and 8 back-to-back rows
//   -> weight_en rows 0..3, then input_en rows 0..3, each 1 cycle after its handshake; ps_pending=1.
// 2 new_weights=0 with fifo_has_space=0 for 5 cycles, then 1 -> row_ready stays 0 for those 5 cycles;
//   input_en rows 0..3 follow; weight_en never asserts.
// 3 Two GEMMs loaded, no partials sent -> ps_pending=2 and gemm_req_ready=0.
//   Send 4 ps rows -> partial_en rows 0..3, ps_pending=1, gemm_req_ready=1.
// 4 Last ps row of GEMM A accepted in the same cycle as the last input row of GEMM B
//   -> ps_pending unchanged; partial_en and input_en both high the next cycle.
// 5 Random valid bubbles on both streams -> row indices contiguous 0..N-1; data matches payload order.
// 6 RST asserted after 2 input rows -> all outputs 0 next cycle, state IDLE; the next GEMM starts at row 0.

Source files
------------

// File: rtl/sysarr_load_sequencer_if.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// sysarr_load_sequencer_if
// Bundles every non-clock/reset signal of the systolic-array load sequencer.
//   Request side : gemm_req_valid, gemm_req_new_weights -> gemm_req_ready
//   Row stream   : row_valid, row_data                  -> row_ready
//   PS stream    : ps_valid, ps_data                    -> ps_ready
//   Control unit : fifo_has_space                       -> input_en, weight_en,
//                  row_in_en, in_row_out, partial_en, row_ps_en, ps_row_out
//   Status       : busy
// Modports: master = upstream/control-unit side, slave = the sequencer.
// ----------------------------------------------------------------------------
interface sysarr_load_sequencer_if #(
    parameter int N  = 4,
    parameter int DW = 16
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic            gemm_req_valid;
    logic            gemm_req_new_weights;
    logic            gemm_req_ready;
    logic            row_valid;
    logic [N*DW-1:0] row_data;
    logic            row_ready;
    logic            ps_valid;
    logic [N*DW-1:0] ps_data;
    logic            ps_ready;
    logic            fifo_has_space;
    logic            input_en;
    logic            weight_en;
    logic [CW-1:0]   row_in_en;
    logic [N*DW-1:0] in_row_out;
    logic            partial_en;
    logic [CW-1:0]   row_ps_en;
    logic [N*DW-1:0] ps_row_out;
    logic            busy;

    modport master (
        output gemm_req_valid, gemm_req_new_weights, row_valid, row_data,
               ps_valid, ps_data, fifo_has_space,
        input  gemm_req_ready, row_ready, ps_ready, input_en, weight_en,
               row_in_en, in_row_out, partial_en, row_ps_en, ps_row_out, busy
    );

    modport slave (
        input  gemm_req_valid, gemm_req_new_weights, row_valid, row_data,
               ps_valid, ps_data, fifo_has_space,
        output gemm_req_ready, row_ready, ps_ready, input_en, weight_en,
               row_in_en, in_row_out, partial_en, row_ps_en, ps_row_out, busy
    );
endinterface

// File: rtl/sysarr_load_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// sysarr_load_sequencer
// Feeds the systolic-array control unit. Accepts GEMM requests, then streams
// N weight rows (optional) and N input rows, gated at GEMM start on the
// control unit's fifo_has_space. Partial-sum rows are accepted concurrently
// for GEMMs whose inputs are loaded (at most MAX_PEND outstanding).
// All strobes, indices and row data are registered: one cycle after the
// accepting handshake.
// Ports:
//   clk  - clock
//   RST  - synchronous reset, active-high
//   bus  - sysarr_load_sequencer_if.slave (request, two row streams,
//          control-unit strobes, busy)
// ----------------------------------------------------------------------------
module sysarr_load_sequencer #(
    parameter int N        = 4,
    parameter int DW       = 16,
    parameter int MAX_PEND = 2
) (
    input  logic                   clk,
    input  logic                   RST,
    sysarr_load_sequencer_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = $clog2(MAX_PEND + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        LOAD_W,
        LOAD_IN
    } state_t;

    state_t          r_state;
    logic            r_new_weights;
    logic [CW-1:0]   r_row_cnt;
    logic [CW-1:0]   r_ps_cnt;
    logic [PW-1:0]   r_ps_pending;
    logic            r_input_en;
    logic            r_weight_en;
    logic [CW-1:0]   r_row_in_en;
    logic [N*DW-1:0] r_in_row_out;
    logic            r_partial_en;
    logic [CW-1:0]   r_row_ps_en;
    logic [N*DW-1:0] r_ps_row_out;

    logic w_req_ready;
    logic w_row_ready;
    logic w_ps_ready;
    logic w_req_fire;
    logic w_row_fire;
    logic w_ps_fire;
    logic w_row_last;
    logic w_ps_last;
    logic w_pend_inc;
    logic w_pend_dec;

    // Ready signals are pure decodes of registered state, so they never
    // depend combinationally on the upstream valids.
    assign w_req_ready = (r_state == IDLE) && (r_ps_pending < PW'(MAX_PEND));
    assign w_row_ready = (r_state == LOAD_W) || (r_state == LOAD_IN);
    assign w_ps_ready  = (r_ps_pending != '0);

    assign w_req_fire  = bus.gemm_req_valid && w_req_ready;
    assign w_row_fire  = bus.row_valid && w_row_ready;
    assign w_ps_fire   = bus.ps_valid && w_ps_ready;
    assign w_row_last  = (r_row_cnt == CW'(N - 1));
    assign w_ps_last   = (r_ps_cnt == CW'(N - 1));

    // A GEMM becomes pending when its last input row lands, and retires when
    // its last partial-sum row lands; both may happen in the same cycle.
    assign w_pend_inc  = w_row_fire && w_row_last && (r_state == LOAD_IN);
    assign w_pend_dec  = w_ps_fire && w_ps_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state       <= IDLE;
            r_new_weights <= 1'b0;
            r_row_cnt     <= '0;
            r_ps_cnt      <= '0;
            r_ps_pending  <= '0;
            r_input_en    <= 1'b0;
            r_weight_en   <= 1'b0;
            r_row_in_en   <= '0;
            r_in_row_out  <= '0;
            r_partial_en  <= 1'b0;
            r_row_ps_en   <= '0;
            r_ps_row_out  <= '0;
        end else begin
            // Strobes pulse for one cycle; index/data hold between handshakes.
            r_input_en   <= w_row_fire && (r_state == LOAD_IN);
            r_weight_en  <= w_row_fire && (r_state == LOAD_W);
            r_partial_en <= w_ps_fire;

            if (w_row_fire) begin
                r_row_in_en  <= r_row_cnt;
                r_in_row_out <= bus.row_data;
                r_row_cnt    <= w_row_last ? '0 : r_row_cnt + 1'b1;
            end

            if (w_ps_fire) begin
                r_row_ps_en  <= r_ps_cnt;
                r_ps_row_out <= bus.ps_data;
                r_ps_cnt     <= w_ps_last ? '0 : r_ps_cnt + 1'b1;
            end

            case ({w_pend_inc, w_pend_dec})
                2'b10:   r_ps_pending <= r_ps_pending + 1'b1;
                2'b01:   r_ps_pending <= r_ps_pending - 1'b1;
                default: r_ps_pending <= r_ps_pending;
            endcase

            case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        r_new_weights <= bus.gemm_req_new_weights;
                        r_state       <= WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    // fifo_has_space only matters here; once loading starts
                    // the GEMM runs to completion.
                    if (bus.fifo_has_space) begin
                        r_state <= r_new_weights ? LOAD_W : LOAD_IN;
                    end
                end
                LOAD_W: begin
                    if (w_row_fire && w_row_last) begin
                        r_state <= LOAD_IN;
                    end
                end
                LOAD_IN: begin
                    if (w_row_fire && w_row_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gemm_req_ready = w_req_ready;
    assign bus.row_ready      = w_row_ready;
    assign bus.ps_ready       = w_ps_ready;
    assign bus.input_en       = r_input_en;
    assign bus.weight_en      = r_weight_en;
    assign bus.row_in_en      = r_row_in_en;
    assign bus.in_row_out     = r_in_row_out;
    assign bus.partial_en     = r_partial_en;
    assign bus.row_ps_en      = r_row_ps_en;
    assign bus.ps_row_out     = r_ps_row_out;
    assign bus.busy           = (r_state != IDLE) || (r_ps_pending != '0);

endmodule

// File: tb/tb_sysarr_load_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_sysarr_load_sequencer
// Directed scenario sequence with random payloads and random valid bubbles.
// A transaction-level model tracks the active GEMM (rows accepted so far),
// the number of pending GEMMs and partial-sum rows accepted, and from those
// predicts every ready, strobe, index and data value each cycle.
// ----------------------------------------------------------------------------
module tb_sysarr_load_sequencer;
    localparam int N        = 4;
    localparam int DW       = 16;
    localparam int MAX_PEND = 2;
    localparam int CW       = (N > 1) ? $clog2(N) : 1;
    localparam int RW       = N * DW;

    logic clk = 1'b0;
    logic RST = 1'b1;

    sysarr_load_sequencer_if #(.N(N), .DW(DW)) bus ();

    sysarr_load_sequencer #(.N(N), .DW(DW), .MAX_PEND(MAX_PEND)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // ---------------- reference model state ----------------
    bit            m_known   = 1'b0;  // DUT state defined (after first reset)
    bit            m_active  = 1'b0;  // a GEMM has been accepted and is loading
    bit            m_waiting = 1'b0;  // accepted but still waiting for FIFO space
    bit            m_nw      = 1'b0;
    int            m_done    = 0;     // rows accepted for the active GEMM
    int            m_pending = 0;     // GEMMs with inputs loaded, partials not
    int            m_ps_done = 0;     // partial rows accepted since reset
    bit            m_req_hs, m_row_hs, m_ps_hs;
    bit            e_input_en, e_weight_en, e_partial_en;
    logic [CW-1:0] e_row_in_en, e_row_ps_en;
    logic [RW-1:0] e_in_row, e_ps_row;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        r = {$urandom(), $urandom()};
        return r;
    endfunction

    // Advance the model across one clock edge, using the inputs as driven.
    task automatic model_edge(input bit r_req, input bit r_row, input bit r_ps);
        int pend_next;
        m_req_hs = 1'b0;
        m_row_hs = 1'b0;
        m_ps_hs  = 1'b0;
        if (RST) begin
            m_known = 1'b1; m_active = 1'b0; m_waiting = 1'b0; m_nw = 1'b0;
            m_done = 0; m_pending = 0; m_ps_done = 0;
            e_input_en = 1'b0; e_weight_en = 1'b0; e_partial_en = 1'b0;
            e_row_in_en = '0; e_row_ps_en = '0; e_in_row = '0; e_ps_row = '0;
            return;
        end
        pend_next    = m_pending;
        e_input_en   = 1'b0;
        e_weight_en  = 1'b0;
        e_partial_en = 1'b0;
        if (bus.row_valid && r_row) begin
            m_row_hs    = 1'b1;
            e_weight_en = m_nw && (m_done < N);
            e_input_en  = !e_weight_en;
            e_row_in_en = CW'(m_done % N);
            e_in_row    = bus.row_data;
            m_done++;
            if (m_done == (m_nw ? 2 * N : N)) begin
                m_active = 1'b0;
                pend_next++;
            end
        end
        if (bus.ps_valid && r_ps) begin
            m_ps_hs      = 1'b1;
            e_partial_en = 1'b1;
            e_row_ps_en  = CW'(m_ps_done % N);
            e_ps_row     = bus.ps_data;
            m_ps_done++;
            if (m_ps_done % N == 0) pend_next--;
        end
        if (m_waiting && bus.fifo_has_space) m_waiting = 1'b0;
        if (bus.gemm_req_valid && r_req) begin
            m_req_hs  = 1'b1;
            m_active  = 1'b1;
            m_waiting = 1'b1;
            m_nw      = bus.gemm_req_new_weights;
            m_done    = 0;
        end
        m_pending = pend_next;
    endtask

    // One clock: check readies/busy before the edge, update the model at the
    // edge, check registered outputs 1 time unit after it.
    task automatic cycle();
        bit r_req, r_row, r_ps;
        r_req = !m_active && (m_pending < MAX_PEND);
        r_row = m_active && !m_waiting;
        r_ps  = (m_pending != 0);
        if (m_known) begin
            check("gemm_req_ready", RW'(bus.gemm_req_ready), RW'(r_req));
            check("row_ready",      RW'(bus.row_ready),      RW'(r_row));
            check("ps_ready",       RW'(bus.ps_ready),       RW'(r_ps));
            check("busy",           RW'(bus.busy),           RW'(m_active || m_pending != 0));
        end
        @(posedge clk);
        model_edge(r_req, r_row, r_ps);
        #1;
        check("input_en",   RW'(bus.input_en),   RW'(e_input_en));
        check("weight_en",  RW'(bus.weight_en),  RW'(e_weight_en));
        check("row_in_en",  RW'(bus.row_in_en),  RW'(e_row_in_en));
        check("in_row_out", bus.in_row_out,      e_in_row);
        check("partial_en", RW'(bus.partial_en), RW'(e_partial_en));
        check("row_ps_en",  RW'(bus.row_ps_en),  RW'(e_row_ps_en));
        check("ps_row_out", bus.ps_row_out,      e_ps_row);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.gemm_req_valid = 1'b0;
        bus.row_valid      = 1'b0;
        bus.ps_valid       = 1'b0;
        cycle();
        RST = 1'b0;
    endtask

    task automatic req(input bit nw);
        bus.gemm_req_valid       = 1'b1;
        bus.gemm_req_new_weights = nw;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (m_req_hs) break;
        end
        bus.gemm_req_valid = 1'b0;
        check("req_accepted", RW'(m_req_hs), RW'(1));
    endtask

    // Offer nrows rows and nps partial rows, each valid dropped with the given
    // percentage; returns once both counts are accepted or the budget expires.
    task automatic run(input int nrows, input int nps, input int bubble);
        int rows_left = nrows;
        int ps_left   = nps;
        bus.gemm_req_valid = 1'b0;
        for (int i = 0; i < 400 && (rows_left > 0 || ps_left > 0); i++) begin
            bus.row_valid = (rows_left > 0) && ($urandom_range(99) >= bubble);
            bus.row_data  = rand_row();
            bus.ps_valid  = (ps_left > 0) && ($urandom_range(99) >= bubble);
            bus.ps_data   = rand_row();
            cycle();
            if (m_row_hs) rows_left--;
            if (m_ps_hs)  ps_left--;
        end
        bus.row_valid = 1'b0;
        bus.ps_valid  = 1'b0;
        check("run_rows_left", RW'(rows_left), RW'(0));
        check("run_ps_left",   RW'(ps_left),   RW'(0));
    endtask

    initial begin
        bus.gemm_req_valid       = 1'b0;
        bus.gemm_req_new_weights = 1'b0;
        bus.row_valid            = 1'b0;
        bus.row_data             = '0;
        bus.ps_valid             = 1'b0;
        bus.ps_data              = '0;
        bus.fifo_has_space       = 1'b1;

        // 1: reset, weights + inputs back-to-back
        do_reset();
        req(1'b1);
        run(2 * N, 0, 0);
        check("t1_pending_one", RW'(bus.ps_ready), RW'(1));

        // 2: FIFO full for 5 cycles, rows offered but not taken
        bus.fifo_has_space = 1'b0;
        req(1'b0);
        bus.row_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.row_data = rand_row();
            cycle();
        end
        bus.row_valid = 1'b0;
        bus.fifo_has_space = 1'b1;
        run(N, 0, 0);

        // 3: two pending -> request blocked; drain one GEMM's partials
        bus.gemm_req_valid = 1'b1;
        cycle();
        check("t3_req_blocked", RW'(m_req_hs), RW'(0));
        bus.gemm_req_valid = 1'b0;
        run(0, N, 0);
        check("t3_req_ready", RW'(bus.gemm_req_ready), RW'(1));

        // 4: last ps row of A coincides with last input row of B
        req(1'b0);
        cycle();
        run(N, N, 0);
        check("t4_both_strobes", RW'({bus.input_en, bus.partial_en}), RW'(2'b11));
        check("t4_pending_same", RW'(bus.ps_ready), RW'(1));

        // 5: random bubbles on both streams over several GEMMs
        for (int g = 0; g < 4; g++) begin
            bit nw = 1'($urandom_range(1));
            req(nw);
            run(nw ? 2 * N : N, N, 40);
        end
        run(0, N * m_pending, 30);

        // 6: reset in the middle of an input load, then a fresh GEMM
        req(1'b0);
        run(2, 0, 0);
        do_reset();
        check("t6_idle", RW'({bus.busy, bus.gemm_req_ready}), RW'(2'b01));
        req(1'b1);
        run(2 * N, N, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
